if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage; producer side of the IF/ID latch interface (drives PCOUT/IR).
//  Owns the PC, issues single-outstanding requests to instruction memory, buffers the returned word,
//  honours pipeline enable, data stall and branch/jump redirect. Outputs NOP while no valid instruction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_INSTR 32'h0000_0013  word presented on IR when IR_valid=0 (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous active-high reset
//  EN           in   1   pipeline enable; 0 freezes PC/consume/redirect
//  Data_stall   in   1   hazard stall; holds current instruction
//  redirect     in   1   taken branch/jump; load PC from redirect_pc
//  redirect_pc  in   32  redirect target; bits[1:0] forced to 0
//  imem_req     out  1   request valid; held with imem_addr stable until imem_ack
//  imem_addr    out  32  request address (word aligned)
//  imem_ack     in   1   response valid this cycle (>=0 cycles after req rises)
//  imem_rdata   in   32  response instruction word
//  PCOUT        out  32  address of word on IR
//  IR           out  32  fetched instruction, NOP_INSTR when !IR_valid
//  IR_valid     out  1   IR/PCOUT hold a real instruction
// BEHAVIOUR
//  Reset (async): state=RST, PC=RESET_PC, req_addr=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   IR=NOP_INSTR, PCOUT=RESET_PC, IR_valid=0. First request issued one cycle after rst deasserts.
//  consume = IR_valid & EN & ~Data_stall. imem_addr = req_addr always.
//  RST  : imem_req=0; next FETCH, req_addr<=PC.
//  FETCH: imem_req=1.
//   EN&redirect: PC<=redirect_pc; ack this cycle -> drop data, req_addr<=redirect_pc, stay FETCH;
//    no ack -> DROP.
//   else ack: IR<=imem_rdata, PCOUT<=req_addr, IR_valid<=1 -> HOLD (ack-to-IR latency 1 cycle).
//  HOLD : imem_req=0. EN&redirect: IR_valid<=0, IR<=NOP, PC<=req_addr<=redirect_pc -> FETCH.
//   else consume: IR_valid<=0, IR<=NOP, PC<=req_addr<=PC+4 -> FETCH. else hold all.
//  DROP : imem_req=1 on stale req_addr until ack. EN&redirect updates PC, stays DROP.
//   on ack: data discarded, req_addr<=PC (or redirect_pc if same-cycle redirect) -> FETCH.
//  Priority: rst > redirect(EN=1) > Data_stall > consume. Redirect ignored when EN=0.
//  imem_ack is captured regardless of EN (memory does not resend); EN=0 only blocks consume/redirect.
//  imem_ack outside FETCH/DROP is ignored. PC+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x0).
//  Max throughput: one instruction per 2 cycles with zero-wait memory (FETCH,HOLD).
//  Downstream: IF/ID captures IR/PCOUT; IR_valid=0 yields a NOP bubble in the latch.
//  Reset mid-request abandons it (imem_req drops asynchronously); memory is reset with the core.
// TESTING
//  1 rst 1->0; cycle1 imem_req=1 addr=0; ack rdata=0x00500093 -> next cycle IR=0x00500093, PCOUT=0, IR_valid=1.
//  2 HOLD + Data_stall=1 for 3 cycles -> IR/PCOUT stable, imem_req=0; release -> next cycle req addr=0x4.
//  3 FETCH addr 0x8 no ack, redirect=1 pc=0x100 -> DROP, req held addr 0x8; ack rdata=0xDEADBEEF
//    -> IR_valid stays 0, IR=0x13; next cycle req addr=0x100.
//  4 redirect pc=0x103 same cycle as ack in FETCH -> data dropped, next req addr=0x100, no DROP cycle.
//  5 EN=0 during FETCH, ack rdata=0x00000073 -> IR_valid=1 captured; PC frozen while EN=0; EN=1 -> consume, addr+4.
//  6 redirect pc=0xFFFFFFFC, fetch+consume -> next req addr=0x0; rst asserted in DROP -> outputs at reset values same cycle.

Source files
------------

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage: the producer side of the IF/ID latch.
// It owns the program counter and issues one instruction-memory request at a
// time. The returned word is buffered on IR/PCOUT until the pipeline consumes
// it. The stage honours the pipeline enable, the data-hazard stall and
// branch/jump redirects. While no valid instruction is held, IR presents
// NOP_INSTR so that downstream sees a bubble.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   EN           in   1   pipeline enable; 0 freezes PC/consume/redirect
//   Data_stall   in   1   hazard stall; holds the current instruction
//   redirect     in   1   taken branch/jump; load PC from redirect_pc
//   redirect_pc  in   32  redirect target (bits [1:0] forced to 0)
//   imem_req     out  1   request valid; address held stable until imem_ack
//   imem_addr    out  32  request address (word aligned)
//   imem_ack     in   1   response valid this cycle
//   imem_rdata   in   32  response instruction word
//   PCOUT        out  32  address of the word on IR
//   IR           out  32  fetched instruction, NOP_INSTR when !IR_valid
//   IR_valid     out  1   IR/PCOUT hold a real instruction
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        Data_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCOUT,
  output logic [31:0] IR,
  output logic        IR_valid
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,  // one idle cycle after reset before the first request
    ST_FETCH = 2'd1,  // request outstanding, response will be kept
    ST_HOLD  = 2'd2,  // instruction buffered, waiting to be consumed
    ST_DROP  = 2'd3   // request outstanding, response must be discarded
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pcout_q, pcout_d;
  logic        ir_valid_q, ir_valid_d;

  logic [31:0] redirect_target;
  logic        take_redirect;
  logic        consume;
  logic [31:0] pc_plus4;

  // Redirect targets are forced to a word boundary.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A redirect only counts while the pipeline is enabled; it outranks the stall.
  assign take_redirect = EN & redirect;
  assign consume       = ir_valid_q & EN & ~Data_stall;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 -> 0x00000000.
  assign pc_plus4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= NOP_INSTR;
      pcout_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      pcout_q    <= pcout_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    pcout_d    = pcout_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      ST_RST: begin
        req_addr_d = pc_q;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        if (take_redirect) begin
          pc_d = redirect_target;
          if (imem_ack) begin
            // The response belongs to the old path; drop it and reissue
            // at the target immediately, without a DROP cycle.
            req_addr_d = redirect_target;
            state_d    = ST_FETCH;
          end else begin
            // The old request is still in flight; it must complete on its
            // original address before the new one can go out.
            state_d = ST_DROP;
          end
        end else if (imem_ack) begin
          // Captured even when EN=0: memory will not resend the word.
          ir_d       = imem_rdata;
          pcout_d    = req_addr_q;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (take_redirect) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP_INSTR;
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
          state_d    = ST_FETCH;
        end else if (consume) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP_INSTR;
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          state_d    = ST_FETCH;
        end
      end

      ST_DROP: begin
        if (take_redirect) begin
          pc_d = redirect_target;
        end
        if (imem_ack) begin
          // Stale data is discarded; the next request uses the newest PC,
          // including a redirect that arrives in this same cycle.
          req_addr_d = take_redirect ? redirect_target : pc_q;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is decoded from the state register only, so an asynchronous
  // reset removes it at once and a request never depends on same-cycle inputs.
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr = req_addr_q;

  assign PCOUT    = pcout_q;
  assign IR       = ir_valid_q ? ir_q : NOP_INSTR;
  assign IR_valid = ir_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic        Data_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PCOUT;
  logic [31:0] IR;
  logic        IR_valid;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_t;

  fetch_t sb_q[$];
  fetch_t exp_f;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .EN          (EN),
    .Data_stall  (Data_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PCOUT       (PCOUT),
    .IR          (IR),
    .IR_valid    (IR_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before limit");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b1; Data_stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || IR !== NOP || PCOUT !== 32'h0 || IR_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b addr=%h IR=%h PC=%h v=%b, want req=0 addr=0 IR=%h PC=0 v=0",
               imem_req, imem_addr, IR, PCOUT, IR_valid, NOP);
    end
    rst = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release_idle: got req=%b, want 0", imem_req);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL first_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    sb_q.push_back('{pc: 32'h0, ir: 32'h0050_0093});
    tick();
    imem_ack = 1'b0;
    exp_f = sb_q.pop_front();
    vectors++;
    if (IR !== exp_f.ir || PCOUT !== exp_f.pc || IR_valid !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL first_capture: got IR=%h PC=%h v=%b req=%b, want IR=%h PC=%h v=1 req=0",
               IR, PCOUT, IR_valid, imem_req, exp_f.ir, exp_f.pc);
    end
    $display("reset/first fetch: IR=%h PCOUT=%h", IR, PCOUT);
  endtask

  task automatic test_stall();
    Data_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (IR !== 32'h0050_0093 || PCOUT !== 32'h0 || IR_valid !== 1'b1 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got IR=%h PC=%h v=%b req=%b, want IR=00500093 PC=0 v=1 req=0",
                 i, IR, PCOUT, IR_valid, imem_req);
      end
    end
    Data_stall = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || IR_valid !== 1'b0 || IR !== NOP) begin
      miscompares++;
      $display("FAIL stall_release: got req=%b addr=%h v=%b IR=%h, want req=1 addr=4 v=0 IR=%h",
               imem_req, imem_addr, IR_valid, IR, NOP);
    end
    // Fetch the word at 0x4 and let it be consumed straight away.
    imem_ack = 1'b1; imem_rdata = 32'h0010_0113;
    sb_q.push_back('{pc: 32'h4, ir: 32'h0010_0113});
    tick();
    imem_ack = 1'b0;
    exp_f = sb_q.pop_front();
    vectors++;
    if (IR !== exp_f.ir || PCOUT !== exp_f.pc || IR_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_4: got IR=%h PC=%h v=%b, want IR=%h PC=%h v=1",
               IR, PCOUT, IR_valid, exp_f.ir, exp_f.pc);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL next_req_8: got req=%b addr=%h, want req=1 addr=8", imem_req, imem_addr);
    end
    $display("stall: released, now requesting %h", imem_addr);
  endtask

  task automatic test_redirect_drop();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || IR_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_hold[%0d]: got req=%b addr=%h v=%b, want req=1 addr=8 v=0",
                 i, imem_req, imem_addr, IR_valid);
      end
      if (i == 0) tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    vectors++;
    if (IR_valid !== 1'b0 || IR !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL drop_discard: got v=%b IR=%h req=%b addr=%h, want v=0 IR=%h req=1 addr=100",
               IR_valid, IR, imem_req, imem_addr, NOP);
    end
    $display("redirect in FETCH: stale data dropped, requesting %h", imem_addr);
  endtask

  task automatic test_redirect_with_ack();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || IR_valid !== 1'b0 || IR !== NOP) begin
      miscompares++;
      $display("FAIL redir_ack: got req=%b addr=%h v=%b IR=%h, want req=1 addr=100 v=0 IR=%h",
               imem_req, imem_addr, IR_valid, IR, NOP);
    end
    // Still in FETCH (not DROP): the next response must be kept.
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    sb_q.push_back('{pc: 32'h100, ir: 32'h1111_1111});
    tick();
    imem_ack = 1'b0;
    exp_f = sb_q.pop_front();
    vectors++;
    if (IR !== exp_f.ir || PCOUT !== exp_f.pc || IR_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL no_drop_cycle: got IR=%h PC=%h v=%b, want IR=%h PC=%h v=1",
               IR, PCOUT, IR_valid, exp_f.ir, exp_f.pc);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      miscompares++;
      $display("FAIL consume_104: got req=%b addr=%h, want req=1 addr=104", imem_req, imem_addr);
    end
    $display("redirect with ack: kept next word, requesting %h", imem_addr);
  endtask

  task automatic test_enable();
    EN = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    sb_q.push_back('{pc: 32'h104, ir: 32'h0000_0073});
    tick();
    imem_ack = 1'b0;
    exp_f = sb_q.pop_front();
    vectors++;
    if (IR !== exp_f.ir || PCOUT !== exp_f.pc || IR_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL en0_capture: got IR=%h PC=%h v=%b, want IR=%h PC=%h v=1",
               IR, PCOUT, IR_valid, exp_f.ir, exp_f.pc);
    end
    // Redirect must be ignored while EN=0.
    redirect = 1'b1; redirect_pc = 32'h400;
    repeat (2) tick();
    redirect = 1'b0;
    vectors++;
    if (IR_valid !== 1'b1 || IR !== 32'h0000_0073 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL en0_frozen: got v=%b IR=%h req=%b, want v=1 IR=00000073 req=0",
               IR_valid, IR, imem_req);
    end
    EN = 1'b1;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h108 || IR_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en1_consume: got req=%b addr=%h v=%b, want req=1 addr=108 v=0",
               imem_req, imem_addr, IR_valid);
    end
    $display("enable: EN=0 captured and held, EN=1 requests %h", imem_addr);
  endtask

  task automatic test_wrap_and_reset();
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    imem_rdata = 32'h2222_2222;
    sb_q.push_back('{pc: 32'hFFFF_FFFC, ir: 32'h2222_2222});
    tick();
    imem_ack = 1'b0;
    exp_f = sb_q.pop_front();
    vectors++;
    if (IR !== exp_f.ir || PCOUT !== exp_f.pc || IR_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_top: got IR=%h PC=%h v=%b, want IR=%h PC=%h v=1",
               IR, PCOUT, IR_valid, exp_f.ir, exp_f.pc);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL pc_wrap: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
    // Redirect with ack to 0x40, then redirect without ack to enter DROP on 0x40.
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    imem_ack = 1'b0; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || PCOUT !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL drop_entry: got req=%b addr=%h PC=%h, want req=1 addr=40 PC=fffffffc",
               imem_req, imem_addr, PCOUT);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || IR !== NOP || PCOUT !== 32'h0 || IR_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b addr=%h IR=%h PC=%h v=%b, want req=0 addr=0 IR=%h PC=0 v=0",
               imem_req, imem_addr, IR, PCOUT, IR_valid, NOP);
    end
    $display("wrap/reset: reset in DROP, req=%b addr=%h", imem_req, imem_addr);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_drop();
    test_redirect_with_ack();
    test_enable();
    test_wrap_and_reset();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
